cn_serial: RTL

- Serial offset-min-sum check-node unit for the LDPC decoder; the counterpart of the variable-node unit.
- Consumes the ROW_WEIGHT variable-to-check messages of one parity-check row, one per cycle. Messages arrive sign-magnitude, matching the VN output format.
- Tracks sign product, min1, min2 and the min1 index, then emits ROW_WEIGHT check-to-variable messages in two's complement, the format the VN consumes.
- Also emits the row syndrome bit for early termination.

---
 rtl/cn_serial.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/cn_serial.sv
// Serial offset-min-sum check-node unit: collects one row of sign-magnitude V2C
// messages, then emits the two's-complement C2V messages and the row syndrome.
module cn_serial #(
  parameter int MSG_WIDTH  = 6,
  parameter int ROW_WEIGHT = 32,
  parameter int OFFSET     = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_v2c_valid,
  output logic                 o_v2c_ready,
  input  logic [MSG_WIDTH-1:0] i_v2c,
  output logic                 o_c2v_valid,
  input  logic                 i_c2v_ready,
  output logic [MSG_WIDTH-1:0] o_c2v,
  output logic                 o_c2v_last,
  output logic                 o_syn
);

  localparam int                 MAG_W   = MSG_WIDTH - 1;
  localparam int                 IDX_W   = $clog2(ROW_WEIGHT);
  localparam logic [MAG_W-1:0]   POS_MAX = '1;
  localparam logic [MAG_W-1:0]   OFF     = MAG_W'(OFFSET);
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(ROW_WEIGHT - 1);

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       k;
  logic [MAG_W-1:0]       min1, min2;
  logic [IDX_W-1:0]       idx;
  logic                   sign_acc;
  logic [ROW_WEIGHT-1:0]  signs;

  // Offset, floor at zero, then sign-apply; negating zero yields zero, so no -0.
  function automatic logic [MSG_WIDTH-1:0] c2v_of(input logic [MAG_W-1:0] mag,
                                                  input logic neg);
    logic [MAG_W-1:0]     m;
    logic [MSG_WIDTH-1:0] r;
    m = (mag > OFF) ? mag - OFF : '0;
    r = {1'b0, m};
    if (neg) r = -r;
    return r;
  endfunction

  // Row state as it would look after accepting the current input.
  logic                  s_in;
  logic [MAG_W-1:0]      m_in;
  logic [MAG_W-1:0]      min1_n, min2_n;
  logic [IDX_W-1:0]      idx_n;
  logic                  sign_acc_n;
  logic [ROW_WEIGHT-1:0] signs_n;
  logic [IDX_W-1:0]      j_n;
  logic [MSG_WIDTH-1:0]  first_c2v, next_c2v;

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    s_in       = i_v2c[MSG_WIDTH-1];
    m_in       = i_v2c[MAG_W-1:0];
    min1_n     = min1;
    min2_n     = min2;
    idx_n      = idx;
    signs_n    = signs;
    signs_n[k] = s_in;
    sign_acc_n = sign_acc ^ s_in;
    if (m_in < min1) begin
      min2_n = min1;
      min1_n = m_in;
      idx_n  = k;
    end else if (m_in < min2) begin
      min2_n = m_in;
    end
    first_c2v = c2v_of((idx_n == '0) ? min2_n : min1_n, sign_acc_n ^ signs_n[0]);
    j_n       = k + IDX_W'(1);
    next_c2v  = c2v_of((j_n == idx) ? min2 : min1, sign_acc ^ signs[j_n]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: the sign store is small flops, not RAM, so it is reset along with the rest.
      state       <= COLLECT;
      k           <= '0;
      min1        <= POS_MAX;
      min2        <= POS_MAX;
      idx         <= '0;
      sign_acc    <= 1'b0;
      signs       <= '0;
      o_v2c_ready <= 1'b1;
      o_c2v_valid <= 1'b0;
      o_c2v       <= '0;
      o_c2v_last  <= 1'b0;
      o_syn       <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (i_v2c_valid && o_v2c_ready) begin
            min1     <= min1_n;
            min2     <= min2_n;
            idx      <= idx_n;
            sign_acc <= sign_acc_n;
            signs    <= signs_n;
            if (k == LAST) begin
              // First output is computed from the post-update row state.
              state       <= EMIT;
              k           <= '0;
              o_v2c_ready <= 1'b0;
              o_c2v_valid <= 1'b1;
              o_c2v       <= first_c2v;
              o_c2v_last  <= 1'b0;
              o_syn       <= sign_acc_n;
            end else begin
              k <= j_n;
            end
          end
        end
        EMIT: begin
          if (i_c2v_ready) begin
            if (k == LAST) begin
              state       <= COLLECT;
              k           <= '0;
              min1        <= POS_MAX;
              min2        <= POS_MAX;
              idx         <= '0;
              sign_acc    <= 1'b0;
              o_v2c_ready <= 1'b1;
              o_c2v_valid <= 1'b0;
              o_c2v       <= '0;
              o_c2v_last  <= 1'b0;
              o_syn       <= 1'b0;
            end else begin
              k          <= j_n;
              o_c2v      <= next_c2v;
              o_c2v_last <= (j_n == LAST);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
